// File: rtl/seq_verify_param.sv
// seq_verify_param: checks framed ASCII sequences of the form <digits><op><letters>.
// A frame opens with a NUL character and is closed by the next NUL.
// The field lengths and the set of accepted operators are parameters.
// Every closed frame produces these results:
//   - a valid or invalid verdict,
//   - a 3-bit error code,
//   - an increment of a saturating counter (valid or invalid),
//   - a strobe pulse STROBE_LEN cycles long for the UART transmit side.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   ascii_char     received character, qualified by char_valid
//   char_valid     one-cycle character strobe
//   sequence_valid verdict of the last evaluated frame
//   output_strobe  high for STROBE_LEN cycles after each evaluation
//   err_code       diagnostic code of the last evaluated frame
//   valid_cnt      saturating count of valid frames
//   invalid_cnt    saturating count of invalid frames
//   busy           a frame is open (state DIG, LET or ERR)
//
// state | meaning
// IDLE  | waiting for the first NUL after reset
// START | NUL seen, the next character opens field 1
// DIG   | collecting digits (dcnt holds the count)
// LET   | operator accepted, collecting letters (lcnt holds the count)
// ERR   | frame already failed, first error code held until NUL
//
// err_code | meaning
// 0        | valid frame
// 1        | first character is not a digit
// 2        | digit count out of range
// 3        | missing or disallowed operator
// 4        | too many letters
// 5        | too few letters
// 6        | bad character in the letter field

module seq_verify_param #(
    parameter int          UART_TX_baud = 20,
    parameter int          freq         = 200,
    parameter int          MIN_DIGITS   = 1,
    parameter int          MAX_DIGITS   = 3,
    parameter int          MIN_LETTERS  = 1,
    parameter int          MAX_LETTERS  = 3,
    parameter logic [3:0]  OP_MASK      = 4'b1111,
    parameter int          CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       ascii_char,
    input  logic             char_valid,
    output logic             sequence_valid,
    output logic             output_strobe,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] valid_cnt,
    output logic [CNT_W-1:0] invalid_cnt,
    output logic             busy
);

    localparam int STROBE_LEN = ((freq / UART_TX_baud) < 1) ? 1 : (freq / UART_TX_baud);
    localparam int SW         = $clog2(STROBE_LEN + 1);
    localparam logic [SW-1:0] STROBE_LOAD = SW'(STROBE_LEN);

    localparam logic [3:0] MIN_D = 4'(MIN_DIGITS);
    localparam logic [3:0] MAX_D = 4'(MAX_DIGITS);
    localparam logic [3:0] MIN_L = 4'(MIN_LETTERS);
    localparam logic [3:0] MAX_L = 4'(MAX_LETTERS);

    localparam logic [2:0] E_OK       = 3'd0;
    localparam logic [2:0] E_START    = 3'd1;
    localparam logic [2:0] E_DIGITS   = 3'd2;
    localparam logic [2:0] E_OPERATOR = 3'd3;
    localparam logic [2:0] E_LET_LONG = 3'd4;
    localparam logic [2:0] E_LET_SHRT = 3'd5;
    localparam logic [2:0] E_LET_BAD  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DIG,
        S_LET,
        S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       dcnt_q, dcnt_d;
    logic [3:0]       lcnt_q, lcnt_d;
    logic [2:0]       err_hold_q, err_hold_d;
    logic             seq_valid_q;
    logic [2:0]       err_code_q;
    logic [CNT_W-1:0] valid_cnt_q, invalid_cnt_q;
    logic [SW-1:0]    strobe_q;

    // Evaluation request for the frame closed by the current NUL.
    logic             eval_en;
    logic             eval_ok;
    logic [2:0]       eval_code;

    // Character classes.
    logic c_nul, c_dig, c_let, c_op;

    always_comb begin
        c_nul = (ascii_char == 8'h00);
        c_dig = (ascii_char >= 8'h30) && (ascii_char <= 8'h39);
        c_let = (ascii_char >= 8'h41) && (ascii_char <= 8'h5A);
        case (ascii_char)
            8'h2B:   c_op = OP_MASK[0];
            8'h2D:   c_op = OP_MASK[1];
            8'h2A:   c_op = OP_MASK[2];
            8'h2F:   c_op = OP_MASK[3];
            default: c_op = 1'b0;
        endcase
    end

    // State register and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            dcnt_q        <= '0;
            lcnt_q        <= '0;
            err_hold_q    <= '0;
            seq_valid_q   <= 1'b0;
            err_code_q    <= '0;
            valid_cnt_q   <= '0;
            invalid_cnt_q <= '0;
            strobe_q      <= '0;
        end else begin
            state_q    <= state_d;
            dcnt_q     <= dcnt_d;
            lcnt_q     <= lcnt_d;
            err_hold_q <= err_hold_d;
            if (eval_en) begin
                seq_valid_q <= eval_ok;
                err_code_q  <= eval_code;
                if (eval_ok) begin
                    if (valid_cnt_q != '1)
                        valid_cnt_q <= valid_cnt_q + CNT_W'(1);
                end else begin
                    if (invalid_cnt_q != '1)
                        invalid_cnt_q <= invalid_cnt_q + CNT_W'(1);
                end
                // A reload while already counting stretches the pulse.
                strobe_q <= STROBE_LOAD;
            end else if (strobe_q != '0) begin
                strobe_q <= strobe_q - 1'b1;
            end
        end
    end

    // Next-state logic; nothing moves without char_valid.
    always_comb begin
        state_d    = state_q;
        dcnt_d     = dcnt_q;
        lcnt_d     = lcnt_q;
        err_hold_d = err_hold_q;
        eval_en    = 1'b0;
        eval_ok    = 1'b0;
        eval_code  = E_OK;
        if (char_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (c_nul)
                        state_d = S_START;
                end
                S_START: begin
                    if (c_nul) begin
                        state_d = S_START;
                    end else if (c_dig) begin
                        state_d = S_DIG;
                        dcnt_d  = 4'd1;
                    end else begin
                        state_d    = S_ERR;
                        err_hold_d = E_START;
                    end
                end
                S_DIG: begin
                    if (c_dig) begin
                        if (dcnt_q < MAX_D) begin
                            dcnt_d = dcnt_q + 4'd1;
                        end else begin
                            state_d    = S_ERR;
                            err_hold_d = E_DIGITS;
                        end
                    end else if (c_op) begin
                        if (dcnt_q >= MIN_D) begin
                            state_d = S_LET;
                            lcnt_d  = 4'd0;
                        end else begin
                            state_d    = S_ERR;
                            err_hold_d = E_DIGITS;
                        end
                    end else if (c_nul) begin
                        state_d   = S_START;
                        eval_en   = 1'b1;
                        eval_code = E_OPERATOR;
                    end else begin
                        state_d    = S_ERR;
                        err_hold_d = E_OPERATOR;
                    end
                end
                S_LET: begin
                    if (c_let) begin
                        if (lcnt_q < MAX_L) begin
                            lcnt_d = lcnt_q + 4'd1;
                        end else begin
                            state_d    = S_ERR;
                            err_hold_d = E_LET_LONG;
                        end
                    end else if (c_nul) begin
                        state_d = S_START;
                        eval_en = 1'b1;
                        if (lcnt_q >= MIN_L) begin
                            eval_ok   = 1'b1;
                            eval_code = E_OK;
                        end else begin
                            eval_code = E_LET_SHRT;
                        end
                    end else begin
                        state_d    = S_ERR;
                        err_hold_d = E_LET_BAD;
                    end
                end
                S_ERR: begin
                    if (c_nul) begin
                        state_d   = S_START;
                        eval_en   = 1'b1;
                        eval_code = err_hold_q;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs.
    always_comb begin
        sequence_valid = seq_valid_q;
        err_code       = err_code_q;
        valid_cnt      = valid_cnt_q;
        invalid_cnt    = invalid_cnt_q;
        output_strobe  = (strobe_q != '0);
        busy           = (state_q == S_DIG) || (state_q == S_LET) || (state_q == S_ERR);
    end

endmodule

// File: tb/tb_seq_verify_param.sv
module tb_seq_verify_param;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ascii_char;
    logic       char_valid;

    logic       sv0, st0, bz0, sv1, st1, bz1, sv2, st2, bz2;
    logic [2:0] ec0, ec1, ec2;
    logic [7:0] vc0, ic0, vc1, ic1;
    logic [1:0] vc2, ic2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // d0: defaults, d1: only '+', d2: tight fields, short strobe, 2-bit counters
    seq_verify_param u_d0 (
        .clk(clk), .rst(rst), .ascii_char(ascii_char), .char_valid(char_valid),
        .sequence_valid(sv0), .output_strobe(st0), .err_code(ec0),
        .valid_cnt(vc0), .invalid_cnt(ic0), .busy(bz0));

    seq_verify_param #(.OP_MASK(4'b0001)) u_d1 (
        .clk(clk), .rst(rst), .ascii_char(ascii_char), .char_valid(char_valid),
        .sequence_valid(sv1), .output_strobe(st1), .err_code(ec1),
        .valid_cnt(vc1), .invalid_cnt(ic1), .busy(bz1));

    seq_verify_param #(.UART_TX_baud(30), .freq(100), .MIN_DIGITS(2), .MAX_DIGITS(2),
                       .MIN_LETTERS(2), .MAX_LETTERS(4), .CNT_W(2)) u_d2 (
        .clk(clk), .rst(rst), .ascii_char(ascii_char), .char_valid(char_valid),
        .sequence_valid(sv2), .output_strobe(st2), .err_code(ec2),
        .valid_cnt(vc2), .invalid_cnt(ic2), .busy(bz2));

    // ---------------- reference model: buffer the frame, judge it on NUL ----------------
    int         cfg_min_d[3], cfg_max_d[3], cfg_min_l[3], cfg_max_l[3];
    int         cfg_strobe[3], cfg_cmax[3];
    logic [3:0] cfg_ops[3];

    bit         m_open[3];
    logic [7:0] fbuf[3][64];
    int         flen[3];
    int         m_seq[3], m_code[3], m_vcnt[3], m_icnt[3], m_strobe[3];

    function automatic bit is_dig(logic [7:0] c);
        return c >= "0" && c <= "9";
    endfunction

    function automatic bit is_let(logic [7:0] c);
        return c >= "A" && c <= "Z";
    endfunction

    function automatic bit is_op(int m, logic [7:0] c);
        logic [3:0] ops;
        ops = cfg_ops[m];
        if (c == "+") return ops[0];
        if (c == "-") return ops[1];
        if (c == "*") return ops[2];
        if (c == "/") return ops[3];
        return 1'b0;
    endfunction

    function automatic int judge(int m);
        int n, k, l;
        n = 0;
        while (n < flen[m] && is_dig(fbuf[m][n])) n++;
        if (n == 0) return 1;
        if (n > cfg_max_d[m]) return 2;
        if (n == flen[m]) return 3;
        if (!is_op(m, fbuf[m][n])) return 3;
        if (n < cfg_min_d[m]) return 2;
        k = n + 1;
        l = 0;
        while (k < flen[m] && is_let(fbuf[m][k])) begin
            l++;
            k++;
        end
        if (l > cfg_max_l[m]) return 4;
        if (k < flen[m]) return 6;
        if (l < cfg_min_l[m]) return 5;
        return 0;
    endfunction

    task automatic model_step(logic [7:0] c, bit v, bit r);
        int code;
        bit ev;
        for (int m = 0; m < 3; m++) begin
            ev = 1'b0;
            if (r) begin
                m_open[m] = 0; flen[m] = 0; m_seq[m] = 0; m_code[m] = 0;
                m_vcnt[m] = 0; m_icnt[m] = 0; m_strobe[m] = 0;
            end else begin
                if (v) begin
                    if (c == 8'h00) begin
                        if (m_open[m] && flen[m] > 0) begin
                            code      = judge(m);
                            m_code[m] = code;
                            m_seq[m]  = (code == 0) ? 1 : 0;
                            if (code == 0) begin
                                if (m_vcnt[m] < cfg_cmax[m]) m_vcnt[m]++;
                            end else begin
                                if (m_icnt[m] < cfg_cmax[m]) m_icnt[m]++;
                            end
                            m_strobe[m] = cfg_strobe[m];
                            ev = 1'b1;
                        end
                        flen[m]   = 0;
                        m_open[m] = 1;
                    end else if (m_open[m] && flen[m] < 64) begin
                        fbuf[m][flen[m]] = c;
                        flen[m]++;
                    end
                end
                if (!ev && m_strobe[m] > 0) m_strobe[m]--;
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    task automatic cmp_dut(int m, logic sv, logic st, logic [2:0] ec, int vc, int ic, logic bz);
        check($sformatf("d%0d sequence_valid", m), int'(sv), m_seq[m]);
        check($sformatf("d%0d output_strobe", m), int'(st), (m_strobe[m] > 0) ? 1 : 0);
        check($sformatf("d%0d err_code", m), int'(ec), m_code[m]);
        check($sformatf("d%0d valid_cnt", m), vc, m_vcnt[m]);
        check($sformatf("d%0d invalid_cnt", m), ic, m_icnt[m]);
        check($sformatf("d%0d busy", m), int'(bz), (m_open[m] && flen[m] > 0) ? 1 : 0);
    endtask

    task automatic tick(logic [7:0] c, bit v, bit r);
        rst        = r;
        ascii_char = c;
        char_valid = v;
        @(posedge clk);
        model_step(c, v, r);
        #1;
        cmp_dut(0, sv0, st0, ec0, int'(vc0), int'(ic0), bz0);
        cmp_dut(1, sv1, st1, ec1, int'(vc1), int'(ic1), bz1);
        cmp_dut(2, sv2, st2, ec2, int'(vc2), int'(ic2), bz2);
    endtask

    task automatic send_frame(string s);
        tick(8'h00, 1'b1, 1'b0);
        for (int i = 0; i < s.len(); i++) tick(s[i], 1'b1, 1'b0);
        tick(8'h00, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        tick(8'h00, 1'b0, 1'b1);
        tick(8'h00, 1'b0, 1'b0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        string frame;
        int    e0;
        int    e1;
        int    e2;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int hi0, hi2, run;
        logic [7:0] c;
        int sel;

        cfg_min_d  = '{1, 1, 2};
        cfg_max_d  = '{3, 3, 2};
        cfg_min_l  = '{1, 1, 2};
        cfg_max_l  = '{3, 3, 4};
        cfg_ops    = '{4'b1111, 4'b0001, 4'b1111};
        cfg_strobe = '{10, 10, 3};
        cfg_cmax   = '{255, 255, 3};

        tbl[0]  = '{"123+X",   0, 0, 2};
        tbl[1]  = '{"1A+XX",   3, 3, 3};
        tbl[2]  = '{"456*ABC", 0, 3, 2};
        tbl[3]  = '{"456*",    5, 3, 2};
        tbl[4]  = '{"1234+A",  2, 2, 2};
        tbl[5]  = '{"12+ABCD", 4, 4, 0};
        tbl[6]  = '{"12*A",    0, 3, 5};
        tbl[7]  = '{"12+A",    0, 0, 5};
        tbl[8]  = '{"X1+A",    1, 1, 1};
        tbl[9]  = '{"12",      3, 3, 3};
        tbl[10] = '{"12+AB3",  6, 6, 6};
        tbl[11] = '{"1+",      5, 5, 2};
        tbl[12] = '{"99/ZZ",   0, 3, 0};
        tbl[13] = '{"+",       1, 1, 1};

        rst = 1'b1; ascii_char = 8'h00; char_valid = 1'b0;
        tick(8'h00, 1'b0, 1'b1);
        tick(8'h00, 1'b1, 1'b1);
        check("reset valid_cnt", int'(vc0), 0);
        check("reset busy", int'(bz0), 0);

        for (int i = 0; i < 14; i++) begin
            send_frame(tbl[i].frame);
            check($sformatf("tbl%0d d0 code", i), int'(ec0), tbl[i].e0);
            check($sformatf("tbl%0d d0 valid", i), int'(sv0), (tbl[i].e0 == 0) ? 1 : 0);
            check($sformatf("tbl%0d d1 code", i), int'(ec1), tbl[i].e1);
            check($sformatf("tbl%0d d1 valid", i), int'(sv1), (tbl[i].e1 == 0) ? 1 : 0);
            check($sformatf("tbl%0d d2 code", i), int'(ec2), tbl[i].e2);
            check($sformatf("tbl%0d d2 valid", i), int'(sv2), (tbl[i].e2 == 0) ? 1 : 0);
        end

        // strobe length and first-result latency
        do_reset();
        send_frame("123+X");
        check("latency seq_valid", int'(sv0), 1);
        check("latency valid_cnt", int'(vc0), 1);
        hi0 = int'(st0);
        hi2 = int'(st2);
        for (int i = 0; i < 30; i++) begin
            tick(8'h00, 1'b0, 1'b0);
            hi0 += int'(st0);
            hi2 += int'(st2);
        end
        check("strobe len d0", hi0, 10);
        check("strobe len d2", hi2, 3);

        // two evaluations 4 cycles apart: one stretched pulse
        send_frame("1+A");
        run = int'(st0);
        tick("2", 1'b1, 1'b0); run += int'(st0);
        tick("+", 1'b1, 1'b0); run += int'(st0);
        tick("B", 1'b1, 1'b0); run += int'(st0);
        tick(8'h00, 1'b1, 1'b0); run += int'(st0);
        for (int i = 0; i < 20; i++) begin
            tick(8'h00, 1'b0, 1'b0);
            run += int'(st0);
        end
        check("stretched strobe", run, 14);
        check("valid_cnt after overlap", int'(vc0), 3);

        // reset mid-frame, reset beats a simultaneous character
        do_reset();
        tick(8'h00, 1'b1, 1'b0);
        tick("1", 1'b1, 1'b0);
        tick("2", 1'b1, 1'b0);
        tick("+", 1'b1, 1'b0);
        check("busy mid-frame", int'(bz0), 1);
        tick(8'h00, 1'b1, 1'b1);
        check("busy after rst", int'(bz0), 0);
        check("valid_cnt after rst", int'(vc0), 0);
        check("invalid_cnt after rst", int'(ic0), 0);
        check("strobe after rst", int'(st0), 0);
        tick("1", 1'b1, 1'b0);
        tick("+", 1'b1, 1'b0);
        tick("A", 1'b1, 1'b0);
        tick(8'h00, 1'b1, 1'b0);
        check("no eval from idle", int'(vc0) + int'(ic0), 0);
        send_frame("7-Q");
        check("valid_cnt after 7-Q", int'(vc0), 1);

        // saturation of the 2-bit counters
        do_reset();
        for (int i = 0; i < 5; i++) send_frame("12+AB");
        check("d2 valid_cnt saturated", int'(vc2), 3);
        check("d0 valid_cnt five", int'(vc0), 5);

        // randomized stream against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 15)      c = 8'h00;
            else if (sel < 45) c = 8'(8'h30 + $urandom_range(0, 9));
            else if (sel < 75) c = 8'(8'h41 + $urandom_range(0, 25));
            else if (sel < 90) begin
                case ($urandom_range(0, 3))
                    0: c = "+";
                    1: c = "-";
                    2: c = "*";
                    default: c = "/";
                endcase
            end else c = 8'($urandom_range(0, 255));
            tick(c, ($urandom_range(0, 3) != 0), ($urandom_range(0, 599) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
